// File: rtl/monster_ctrl_if.sv
// Ghost controller bus: game/maze side (master) and ghost controller (slave).
interface monster_ctrl_if #(
    parameter int W = 9
);
    logic         enable;
    logic         tick;
    logic [W-1:0] p_x;
    logic [W-1:0] p_y;
    logic [3:0]   blk;
    logic         power;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   dir;
    logic [1:0]   mode;
    logic         caught;
    logic         eaten;

    modport master (
        output enable, tick, p_x, p_y, blk, power,
        input  x, y, dir, mode, caught, eaten
    );

    modport slave (
        input  enable, tick, p_x, p_y, blk, power,
        output x, y, dir, mode, caught, eaten
    );
endinterface

// File: rtl/monster_ctrl.sv
// Pacman ghost controller: home release, CHASE/SCATTER stepping, catch flag.
// Optional FRIGHT mode (power pellet, eaten respawn) enabled by FRIGHT_MODE_EN.
module monster_ctrl #(
    parameter int INDEX         = 1,
    parameter int W             = 9,
    parameter int HOME_X        = 0,
    parameter int HOME_Y        = 0,
    parameter int CORNER_X      = 0,
    parameter int CORNER_Y      = 0,
    parameter int MAX_X         = 319,
    parameter int MAX_Y         = 239,
    parameter int STEP_DIV      = 2,
    parameter int RELEASE_TICKS = 60,
    parameter int CHASE_TICKS   = 400,
    parameter int SCATTER_TICKS = 100
) (
    input logic           clk,
    input logic           rst,
    monster_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        M_HOME    = 2'd0,
        M_CHASE   = 2'd1,
        M_SCATTER = 2'd2,
        M_FRIGHT  = 2'd3
    } mode_t;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam logic [W-1:0] HX   = W'(HOME_X);
    localparam logic [W-1:0] HY   = W'(HOME_Y);
    localparam logic [W-1:0] CX   = W'(CORNER_X);
    localparam logic [W-1:0] CY   = W'(CORNER_Y);
    localparam logic [W-1:0] MXX  = W'(MAX_X);
    localparam logic [W-1:0] MXY  = W'(MAX_Y);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [31:0]  REL  = 32'(INDEX * RELEASE_TICKS);
    localparam logic [31:0]  CHT  = 32'(CHASE_TICKS);
    localparam logic [31:0]  SCT  = 32'(SCATTER_TICKS);
    localparam logic [31:0]  FRT  = 32'(4 * SCATTER_TICKS);
    localparam logic [31:0]  DIV  = 32'(STEP_DIV);
    localparam logic [31:0]  DIV2 = 32'(2 * STEP_DIV);

    mode_t        mode_q, mode_n;
    logic [31:0]  mcnt_q, mcnt_n, scnt_q, scnt_n, mc1, sc1;
    logic [W-1:0] x_q, x_n, y_q, y_n;
    logic [1:0]   dir_q, dir_n;
    logic         caught_q, caught_n, eaten_q, eaten_n;
    logic         etick, hit, step;

    logic [W-1:0]      tx, ty, nx, ny;
    logic signed [W:0] dx, dy;
    logic [W:0]        adx, ady;
    logic [1:0]        xdir, ydir, ndir, flip;
    logic              xprim;
    logic [1:0]        cand [7];
    logic              cv   [7];

    assign etick = bus.enable & bus.tick;

    // Direction choice: walk the priority list, first unblocked candidate wins
    always_comb begin
        tx    = (mode_q == M_SCATTER) ? CX : bus.p_x;
        ty    = (mode_q == M_SCATTER) ? CY : bus.p_y;
        dx    = $signed({1'b0, tx}) - $signed({1'b0, x_q});
        dy    = $signed({1'b0, ty}) - $signed({1'b0, y_q});
        adx   = dx[W] ? -dx : dx;
        ady   = dy[W] ? -dy : dy;
        flip  = (mode_q == M_FRIGHT) ? 2'b10 : 2'b00;
        xdir  = (dx[W] ? D_LEFT : D_RIGHT) ^ flip;
        ydir  = (dy[W] ? D_UP : D_DOWN) ^ flip;
        xprim = adx >= ady;
        cand[0] = xprim ? xdir : ydir;
        cv[0]   = xprim ? (dx != 0) : (dy != 0);
        cand[1] = xprim ? ydir : xdir;
        cv[1]   = xprim ? (dy != 0) : (dx != 0);
        cand[2] = dir_q;
        cv[2]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cand[3+i] = 2'(i);
            cv[3+i]   = 1'b1;
        end
        ndir = dir_q;
        nx   = x_q;
        ny   = y_q;
        for (int i = 6; i >= 0; i--) begin
            if (cv[i] && !bus.blk[2'd3 - cand[i]]) ndir = cand[i];
        end
        if (!bus.blk[2'd3 - ndir]) begin
            case (ndir)
                D_UP:    if (y_q != '0) ny = y_q - ONE;
                D_LEFT:  if (x_q != '0) nx = x_q - ONE;
                D_DOWN:  if (y_q < MXY) ny = y_q + ONE;
                default: if (x_q < MXX) nx = x_q + ONE;
            endcase
        end
    end

    always_comb begin
        mode_n   = mode_q;
        mcnt_n   = mcnt_q;
        scnt_n   = scnt_q;
        x_n      = x_q;
        y_n      = y_q;
        dir_n    = dir_q;
        eaten_n  = 1'b0;
        hit      = (x_q == bus.p_x) && (y_q == bus.p_y);
        caught_n = hit && (mode_q == M_CHASE || mode_q == M_SCATTER);
        mc1      = mcnt_q + 32'd1;
        sc1      = scnt_q + 32'd1;
        step     = etick && (mode_q != M_HOME) &&
                   (sc1 >= ((mode_q == M_FRIGHT) ? DIV2 : DIV));
        if (etick && mode_q != M_HOME) scnt_n = step ? '0 : sc1;
        if (step) begin
            x_n   = nx;
            y_n   = ny;
            dir_n = ndir;
        end
        case (mode_q)
            M_HOME: begin
                scnt_n = '0;
                if (etick) begin
                    if (mc1 >= REL) begin
                        mode_n = M_CHASE;
                        mcnt_n = '0;
                    end else begin
                        mcnt_n = mc1;
                    end
                end
            end
            M_CHASE: if (etick) begin
                if (mc1 >= CHT) begin
                    mode_n = M_SCATTER;
                    mcnt_n = '0;
                end else begin
                    mcnt_n = mc1;
                end
            end
            M_SCATTER: if (etick) begin
                if (mc1 >= SCT) begin
                    mode_n = M_CHASE;
                    mcnt_n = '0;
                end else begin
                    mcnt_n = mc1;
                end
            end
            default: if (etick) begin
                if (mc1 >= FRT) begin
                    mode_n = M_CHASE;
                    mcnt_n = '0;
                    scnt_n = '0;
                end else begin
                    mcnt_n = mc1;
                end
            end
        endcase
`ifdef FRIGHT_MODE_EN
        if (bus.enable) begin
            if (mode_q == M_FRIGHT && hit) begin
                eaten_n = 1'b1;
                x_n     = HX;
                y_n     = HY;
                mode_n  = M_HOME;
                mcnt_n  = '0;
                scnt_n  = '0;
            end else if (bus.power && mode_q != M_HOME) begin
                mode_n = M_FRIGHT;
                mcnt_n = '0;
                if (mode_q != M_FRIGHT) begin
                    scnt_n = '0;
                    if (!bus.blk[2'd3 - (dir_q ^ 2'b10)]) dir_n = dir_q ^ 2'b10;
                end
            end
        end
`endif
    end

`ifndef FRIGHT_MODE_EN
    wire unused_power = bus.power;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= M_HOME;
            mcnt_q   <= '0;
            scnt_q   <= '0;
            x_q      <= HX;
            y_q      <= HY;
            dir_q    <= D_UP;
            caught_q <= 1'b0;
            eaten_q  <= 1'b0;
        end else begin
            mode_q   <= mode_n;
            mcnt_q   <= mcnt_n;
            scnt_q   <= scnt_n;
            x_q      <= x_n;
            y_q      <= y_n;
            dir_q    <= dir_n;
            caught_q <= caught_n;
            eaten_q  <= eaten_n;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.dir    = dir_q;
    assign bus.mode   = mode_q;
    assign bus.caught = caught_q;
    assign bus.eaten  = eaten_q;

endmodule
